// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, types and write-port arbitration for regfile_mp
package regfile_pkg;

  localparam int DEF_XLEN     = 32;
  localparam int DEF_NREGS    = 32;
  localparam int DEF_NRD      = 2;
  localparam int DEF_NWR      = 2;
  localparam int DEF_SP_IDX   = 2;
  localparam int DEF_SP_RESET = 2048;
  localparam int DEF_AW       = $clog2(DEF_NREGS);

  // Ceiling on what wr_select can arbitrate; callers zero-extend into these widths.
  localparam int MAX_NWR = 8;
  localparam int MAX_AW  = 8;
  localparam int WSEL_W  = $clog2(MAX_NWR);

  typedef logic [DEF_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] xlen_t;

  typedef struct packed {
    logic              hit;
    logic [WSEL_W-1:0] idx;
  } wr_sel_t;

  // Winning write port for addr: the highest-indexed enabled port whose
  // address matches. Addresses are packed at stride aw inside addrs.
  function automatic wr_sel_t wr_select(
    input logic [MAX_NWR-1:0]        en,
    input logic [MAX_NWR*MAX_AW-1:0] addrs,
    input logic [MAX_AW-1:0]         addr,
    input int                        nwr,
    input int                        aw
  );
    wr_sel_t           s;
    logic [MAX_AW-1:0] mask;
    logic [MAX_AW-1:0] a_i;
    s    = '0;
    mask = MAX_AW'((1 << aw) - 1);
    for (int i = 0; i < MAX_NWR; i++) begin
      a_i = MAX_AW'(addrs >> (i * aw)) & mask;
      if ((i < nwr) && en[i] && (a_i == addr)) begin
        s.hit = 1'b1;
        s.idx = WSEL_W'(i);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with allocate/release and read lookup
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = DEF_NREGS,
  parameter  int NRD   = DEF_NRD,
  parameter  int NWR   = DEF_NWR,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  // Register 0 never holds a producer, so its bit is masked off permanently.
  localparam logic [NREGS-1:0] LIVE_MASK = {{(NREGS-1){1'b1}}, 1'b0};

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_rel;
  logic [NREGS-1:0] w_set;

  // Decode releases (any write port) and the single allocation into one-hot vectors.
  always_comb begin
    w_rel = '0;
    w_set = '0;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w]) begin
        w_rel[wr_addr[w*AW +: AW]] = 1'b1;
      end
    end
    if (alloc_en) begin
      w_set[alloc_addr] = 1'b1;
    end
  end

  // Allocation outranks a same-cycle release: the new producer is still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_rel) | w_set) & LIVE_MASK;
    end
  end

  // Registered busy lookup per read port.
  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_busy[p] = r_busy[rd_addr[p*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with busy scoreboard; REGFILE_BYPASS_EN adds write-through reads
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN     = DEF_XLEN,
  parameter  int NREGS    = DEF_NREGS,
  parameter  int NRD      = DEF_NRD,
  parameter  int NWR      = DEF_NWR,
  parameter  int SP_IDX   = DEF_SP_IDX,
  parameter  int SP_RESET = DEF_SP_RESET,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr
);

  logic [MAX_NWR-1:0]        w_wr_en_x;
  logic [MAX_NWR*MAX_AW-1:0] w_wr_addr_x;
  logic [XLEN-1:0]           r_regs     [1:NREGS-1];
  logic [XLEN-1:0]           w_rd_array [NREGS];
  wr_sel_t                   w_wsel     [1:NREGS-1];
  logic [NRD-1:0]            w_sb_busy;

  assign w_wr_en_x     = MAX_NWR'(wr_en);
  assign w_wr_addr_x   = (MAX_NWR*MAX_AW)'(wr_addr);
  assign w_rd_array[0] = '0;

  for (genvar g = 1; g < NREGS; g++) begin : g_reg
    localparam logic [XLEN-1:0] RST_VAL = (g == SP_IDX) ? XLEN'(SP_RESET) : '0;

    assign w_wsel[g]     = wr_select(w_wr_en_x, w_wr_addr_x, MAX_AW'(g), NWR, AW);
    assign w_rd_array[g] = r_regs[g];

    // Register g takes the data of the highest-indexed port writing it.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_regs[g] <= RST_VAL;
      end else if (w_wsel[g].hit) begin
        r_regs[g] <= wr_data[w_wsel[g].idx*XLEN +: XLEN];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .rd_addr    (rs_addr),
    .rd_busy    (w_sb_busy)
  );

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] w_ra;
    assign w_ra = rs_addr[p*AW +: AW];

`ifdef REGFILE_BYPASS_EN
    wr_sel_t w_bsel;
    assign w_bsel = wr_select(w_wr_en_x, w_wr_addr_x, MAX_AW'(w_ra), NWR, AW);

    // Same-cycle writes forward to the reader and retire the pending producer,
    // unless a fresh allocation of the same register lands in this cycle too.
    always_comb begin
      rs_data[p*XLEN +: XLEN] = w_rd_array[w_ra];
      rs_busy[p]              = w_sb_busy[p];
      if (w_bsel.hit && (w_ra != '0)) begin
        rs_data[p*XLEN +: XLEN] = wr_data[w_bsel.idx*XLEN +: XLEN];
        if (!(alloc_en && (alloc_addr == w_ra))) begin
          rs_busy[p] = 1'b0;
        end
      end
    end
`else
    // Array-only read: same-cycle writes become visible after the edge.
    always_comb begin
      rs_data[p*XLEN +: XLEN] = w_rd_array[w_ra];
      rs_busy[p]              = w_sb_busy[p];
    end
`endif
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, dual-read core register file.
- Configurable width, register count, read-port count and write-port count.
- Per-register busy scoreboard so the issue stage can detect RAW hazards on in-flight destinations.
- Sits between decode/issue (read, allocate) and writeback (write, release) in the core pipeline.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of two, >=2); register 0 hardwired to zero.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- SP_IDX, 2, index of the stack-pointer register given a non-zero reset value.
- SP_RESET, 2048, reset value of register SP_IDX.
- AW, $clog2(NREGS), address width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- rs_addr  input  NRD*AW  read addresses; port p at bits [p*AW +: AW].
- rs_data  output  NRD*XLEN  read data; port p at bits [p*XLEN +: XLEN].
- rs_busy  output  NRD  1 = register addressed by port p has an outstanding producer.
- wr_en  input  NWR  write enable per write port.
- wr_addr  input  NWR*AW  write addresses.
- wr_data  input  NWR*XLEN  write data.
- alloc_en  input  1  issue stage allocates a destination; sets its busy bit.
- alloc_addr  input  AW  destination being allocated.

Behaviour:
- Clock and reset: one clock, clk; rst is asynchronous, active-low.
- Reset (rst=0, asynchronous):
  - All registers 1..NREGS-1 clear to 0, except register SP_IDX, which loads SP_RESET.
  - All busy bits clear.
  - Reset mid-operation discards pending writes and allocations in that cycle.
- Storage: registers 1..NREGS-1 only. Reads of address 0 return 0 with rs_busy=0. Writes and allocations to address 0 are ignored.
- Write:
  - On the rising edge, each port with wr_en=1 and wr_addr!=0 updates its register.
  - Same-address collision across ports: the highest-indexed port wins.
  - Write latency 1 cycle; new value visible at the array output the cycle after the edge.
- Read: combinational from array (or bypass, see Optional Feature); zero cycles from rs_addr change.
- Scoreboard (per register r, 1..NREGS-1):
  - Busy bit set at the edge when alloc_en=1 and alloc_addr=r.
  - Cleared at the edge when any write port writes r.
  - Allocate and write of the same r in the same cycle: busy stays 1, since the allocation is a newer producer. Data is still written.
  - Allocate an already-busy r: stays 1, no counting; the single most-recent producer releases it.
  - rs_busy[p] reflects the busy bit registered state; it is not bypassed.
- Writes to a non-busy register are legal and update data; busy stays 0.
- No X propagation: an out-of-range address cannot occur because NREGS is a power of two.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass on reads.
  - If any wr_en[w]=1 with wr_addr[w]==rs_addr[p]!=0 in the current cycle, rs_data[p] returns wr_data of the highest-indexed matching port instead of the array value.
  - rs_busy[p] is forced 0 for that port in that cycle unless alloc_en targets the same address.
- Undefined: reads return only the array contents; a value written this cycle is visible next cycle. rs_busy is purely the registered bit.

Decomposition:
- Package regfile_pkg:
  - Default XLEN/NREGS constants.
  - SP_IDX/SP_RESET defaults.
  - typedef reg_addr_t (logic [AW-1:0]) and xlen_t.
  - Function wr_select that returns the winning write port index for an address.
- Sub-module regfile_scoreboard holds the NREGS busy bits with alloc/release logic and NRD lookup outputs.
- Data array and read/bypass muxing stay in the top.

Test Plan:
- Reset: assert rst=0 mid-cycle, release → reading r2 gives 2048, r5 gives 0, all rs_busy=0.
- Dual write, different registers: port0 writes r3=0x11, port1 writes r4=0x22 → next cycle r3=0x11, r4=0x22.
- Same address on both ports: port0 writes r7=0xAAAA, port1 writes r7=0x5555 → r7=0x5555.
- r0 handling: wr r0=0xFFFF and alloc r0 → r0 reads 0 with busy 0.
- Scoreboard:
  - alloc r9 → rs_busy=1 next cycle.
  - write r9=0x42 → busy 0 and data 0x42.
  - alloc r9 plus write r9 in the same cycle → busy remains 1.
- Bypass: with REGFILE_BYPASS_EN, write r12=0xDEAD while reading r12 in the same cycle → rs_data=0xDEAD. Without the macro → old value that cycle, 0xDEAD next cycle.
